tdm_frame_converter: RTL
========================

Name: tdm_frame_converter

Overview:
- Parametrised successor to the single-bit f0/c4 pass-through converter.
- Runs in the clk50 domain and serialises and deserialises a full ST-bus style TDM frame of CHANNELS x WIDTH bits, framed by f0 and bit-clocked by c4.
- Double-buffers the RX and TX frames and exposes them to the STM host through a register port with a frame interrupt.
- Adds an optional loopback mode and overrun/short-frame error flags.

Parameters:
CHANNELS, 4, timeslots per frame (2..32)
WIDTH, 8, bits per timeslot, MSB first (4..16)
BIT_DIV, 2, c4 periods per bit cell (1..8)
AW, 6, host address width; must satisfy 2^AW > CHANNELS

Ports:
clk50  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous active-low reset
f0  in  1  frame pulse, active low, asynchronous to clk50
c4  in  1  TDM bit-rate clock, asynchronous
data_from_dt  in  1  TDM serial receive data
data_to_dt  out  1  TDM serial transmit data
select  in  1  1 = loopback: transmit the receive stream delayed by one frame
host_addr  in  AW  register address
host_we  in  1  write strobe, one clk50 per write
host_wdata  in  WIDTH  write data
host_rdata  out  WIDTH  read data, registered
cpu_int  out  1  frame-ready interrupt, level

Behaviour:
Reset values:
- data_to_dt=1, host_rdata=0, cpu_int=0.
- All buffers and flags 0; FSM in IDLE.
- Reset mid-frame abandons the frame with no buffer swap.

Input synchronisation:
- f0, c4 and data_from_dt each pass through 2-flop synchronisers.
- Edge detectors give one-cycle pulses f0_fall, c4_rise and c4_fall.
- Minimum clk50 period is one quarter of the c4 period or shorter.

FSM has three states: IDLE, ACTIVE, DONE.
- IDLE:
  - data_to_dt=1.
  - On f0_fall: load tx_shift from the TX active buffer (slot 0 MSB first), clear bit_cnt and div_cnt, go to ACTIVE.
- ACTIVE, transmit:
  - data_to_dt presents the current bit from the cycle after entry.
  - On c4_fall with div_cnt==BIT_DIV-1: advance to the next bit and reset div_cnt; otherwise increment div_cnt on c4_fall.
- ACTIVE, receive:
  - On c4_rise while div_cnt==BIT_DIV-1: sample data_from_dt into rx_shift.
  - The sample is written to the RX working buffer slot bit_cnt/WIDTH at position WIDTH-1-(bit_cnt mod WIDTH).
  - After the sample with bit_cnt==CHANNELS*WIDTH-1, go to DONE.
- ACTIVE, short frame:
  - On f0_fall in ACTIVE, set frame_err and restart the frame as if from IDLE. No swap.
- DONE (exactly one cycle):
  - Swap RX working into RX holding.
  - Copy TX staging into TX active.
  - If cpu_int is already 1, set overrun.
  - Set cpu_int=1 and go to IDLE.
  - data_to_dt returns to 1 until the next f0_fall.

Loopback (select=1):
- TX active is loaded from RX holding instead of TX staging at DONE.
- select is sampled only at DONE; a change mid-frame takes effect next frame.

Host registers:
- addr < CHANNELS:
  - Read returns RX holding[addr].
  - Write stores to TX staging[addr].
- addr == CHANNELS, status:
  - Read returns {0..., frame_err, overrun, cpu_int} in bits 2..0.
  - Write is W1C on those three bits.
- Other addresses read 0; writes to them are ignored.
- host_rdata is valid one clk50 after host_addr is presented.
- Simultaneous DONE set and host W1C clear of cpu_int in the same cycle: set wins, so cpu_int stays 1.
- Host writes to TX staging in the DONE cycle land in staging and are not part of the copy. The new value is sent in the frame after next.

Widths:
- bit_cnt uses clog2(CHANNELS*WIDTH) bits.
- div_cnt uses clog2(BIT_DIV)+1 bits. It wraps at BIT_DIV-1 and never counts past it.

Test Plan:
1. Defaults, TX staging = {A5,3C,FF,00}, two frames of 64 c4 periods -> data_to_dt in frame 2 = A5 3C FF 00 MSB first, bit edges every 2nd c4 fall; cpu_int rises 1 cycle after the 32nd sample.
2. Drive data_from_dt with slots 12,34,56,78 -> after DONE, reads of addr 0..3 return 12,34,56,78 with 1-cycle latency; status reads 1; write status 1 -> cpu_int=0.
3. Leave cpu_int unacknowledged across a second frame -> status = 3 (overrun + int); W1C with 3 -> 0.
4. f0_fall after 10 bits -> frame_err=1, holding buffer unchanged, new frame completes normally 32 bits after the second f0.
5. select=1, receive 81,42,24,18 in frame N -> data_to_dt in frame N+1 carries 81,42,24,18.
6. Assert reset_n low at bit 17 -> data_to_dt=1 and cpu_int=0 immediately. The next full frame completes with no residual bits.

Source files
------------

// File: rtl/tdm_frame_converter.sv
// ST-bus style TDM frame converter: serialises/deserialises CHANNELS x WIDTH
// bit frames, double-buffered behind a host register port with frame interrupt.
module tdm_frame_converter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int BIT_DIV  = 2,
  parameter int AW       = 6
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             f0,
  input  logic             c4,
  input  logic             data_from_dt,
  output logic             data_to_dt,
  input  logic             select,
  input  logic [AW-1:0]    host_addr,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             cpu_int
);

  localparam int NBITS = CHANNELS * WIDTH;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = $clog2(BIT_DIV) + 1;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [AW-1:0] STAT_ADDR = AW'(CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]       r_f0_sr, r_c4_sr;
  logic [1:0]       r_d_sr;
  logic             w_f0_fall, w_c4_rise, w_c4_fall, w_din;
  logic             w_load, w_short, w_adv, w_sample, w_done;

  logic [NBITS-1:0] r_tx_shift, r_rx_work, w_tx_flat;
  logic [BW-1:0]    r_bit_cnt, w_rx_idx;
  logic [DW-1:0]    r_div_cnt;

  logic [CHANNELS-1:0][WIDTH-1:0] r_tx_stage, r_tx_active, r_rx_hold, w_rx_slots;

  logic             r_cpu_int, r_overrun, r_frame_err;
  logic [WIDTH-1:0] r_rdata;
  logic [CW-1:0]    w_slot;
  logic             w_addr_slot, w_addr_stat;
  logic [2:0]       w_w1c;

  // f0/c4/data share the same synchroniser depth so data stays aligned to c4
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_f0_sr <= '1;
      r_c4_sr <= '0;
      r_d_sr  <= '0;
    end else begin
      r_f0_sr <= {r_f0_sr[1:0], f0};
      r_c4_sr <= {r_c4_sr[1:0], c4};
      r_d_sr  <= {r_d_sr[0], data_from_dt};
    end
  end

  assign w_f0_fall =  r_f0_sr[2] & ~r_f0_sr[1];
  assign w_c4_rise = ~r_c4_sr[2] &  r_c4_sr[1];
  assign w_c4_fall =  r_c4_sr[2] & ~r_c4_sr[1];
  assign w_din     =  r_d_sr[1];

  // Slot 0 travels first, so it sits at the MSB end of the serial vectors
  for (genvar c = 0; c < CHANNELS; c++) begin : g_map
    assign w_tx_flat[(CHANNELS-1-c)*WIDTH +: WIDTH] = r_tx_active[c];
    assign w_rx_slots[c] = r_rx_work[(CHANNELS-1-c)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_short     = 1'b0;
    w_adv       = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_f0_fall) begin
          w_load      = 1'b1;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_f0_fall) begin
          w_load  = 1'b1;
          w_short = 1'b1;
        end else begin
          w_adv    = w_c4_fall;
          w_sample = w_c4_rise && (r_div_cnt == DIV_LAST);
          if (w_sample && (r_bit_cnt == BIT_LAST)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rx_idx   = BIT_LAST - r_bit_cnt;
  assign data_to_dt = (r_state == S_ACTIVE) ? r_tx_shift[NBITS-1] : 1'b1;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift <= '0;
      r_rx_work  <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_tx_shift <= w_tx_flat;
        r_bit_cnt  <= '0;
        r_div_cnt  <= '0;
      end else if (w_adv) begin
        if (r_div_cnt == DIV_LAST) begin
          r_tx_shift <= {r_tx_shift[NBITS-2:0], 1'b0};
          r_bit_cnt  <= r_bit_cnt + BW'(1);
          r_div_cnt  <= '0;
        end else begin
          r_div_cnt  <= r_div_cnt + DW'(1);
        end
      end
      if (w_sample) r_rx_work[w_rx_idx] <= w_din;
    end
  end

  assign w_slot      = host_addr[CW-1:0];
  assign w_addr_slot = (host_addr < STAT_ADDR);
  assign w_addr_stat = (host_addr == STAT_ADDR);
  assign w_w1c       = (host_we && w_addr_stat) ? host_wdata[2:0] : 3'b000;

  // Staging writes in the DONE cycle miss the copy (NBA reads the old value)
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_stage  <= '0;
      r_tx_active <= '0;
      r_rx_hold   <= '0;
      r_cpu_int   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (host_we && w_addr_slot) r_tx_stage[w_slot] <= host_wdata;
      if (w_done) begin
        r_rx_hold   <= w_rx_slots;
        r_tx_active <= select ? w_rx_slots : r_tx_stage;
      end
      r_cpu_int   <= (r_cpu_int   & ~w_w1c[0]) | w_done;
      r_overrun   <= (r_overrun   & ~w_w1c[1]) | (w_done & r_cpu_int);
      r_frame_err <= (r_frame_err & ~w_w1c[2]) | w_short;
      if (w_addr_slot)      r_rdata <= r_rx_hold[w_slot];
      else if (w_addr_stat) r_rdata <= {{(WIDTH-3){1'b0}}, r_frame_err, r_overrun, r_cpu_int};
      else                  r_rdata <= '0;
    end
  end

  assign host_rdata = r_rdata;
  assign cpu_int    = r_cpu_int;

endmodule
